// File: rtl/xilinx_pcie_tx_pkg.sv
// xilinx_pcie_tx_pkg: shared FSM encoding, payload sizing and arbitration helper for the PCIe TX arbiter
package xilinx_pcie_tx_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_PKT, ST_DRAIN} tx_state_t;
  localparam int TX_CTRL_W = 2;
  function automatic logic [3:0] onehot_rr(input logic [3:0] valid, input logic [1:0] ptr);
    logic [1:0] idx;
    onehot_rr = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (valid[idx]) onehot_rr = 4'b0001 << idx;
    end
  endfunction
endpackage

// File: rtl/xilinx_pcie_axis_skid.sv
// xilinx_pcie_axis_skid: 2-entry registered slice decoupling core ready from source logic
module xilinx_pcie_axis_skid #(
  parameter int P_W = 146
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_valid,
  input  logic [P_W-1:0] i_data,
  output logic           o_ready,
  output logic           o_valid,
  output logic [P_W-1:0] o_data,
  input  logic           i_ready
);
  logic [1:0]     r_cnt;
  logic [P_W-1:0] r_d0, r_d1;
  logic           w_push, w_pop;
  assign o_ready = r_cnt != 2'd2;
  assign o_valid = r_cnt != 2'd0;
  assign o_data  = r_d0;
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_d0  <= '0;
      r_d1  <= '0;
    end else begin
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
      if (w_pop) r_d0 <= (r_cnt == 2'd2) ? r_d1 : i_data;
      else if (w_push && r_cnt == 2'd0) r_d0 <= i_data;
      if (w_push) r_d1 <= i_data;
    end
  end
endmodule

// File: rtl/xilinx_pcie_tx_arbiter.sv
// xilinx_pcie_tx_arbiter: per-TLP arbiter sharing the PCIe core AXIS TX port, with stall watchdog abort
module xilinx_pcie_tx_arbiter
  import xilinx_pcie_tx_pkg::*;
#(
  parameter int P_DATA_WIDTH = 128,
  parameter int P_KEEP_WIDTH = P_DATA_WIDTH / 8,
  parameter int P_NUM_SRC    = 2,
  parameter int P_TIMEOUT    = 1024
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [P_NUM_SRC*P_DATA_WIDTH-1:0] s_src_tdata,
  input  logic [P_NUM_SRC*P_KEEP_WIDTH-1:0] s_src_tkeep,
  input  logic [P_NUM_SRC-1:0]              s_src_tlast,
  input  logic [P_NUM_SRC-1:0]              s_src_tvalid,
  output logic [P_NUM_SRC-1:0]              s_src_tready,
  input  logic                              s_axis_tx_tready,
  output logic [P_DATA_WIDTH-1:0]           s_axis_tx_tdata,
  output logic [P_KEEP_WIDTH-1:0]           s_axis_tx_tkeep,
  output logic                              s_axis_tx_tlast,
  output logic                              s_axis_tx_tvalid,
  output logic                              tx_src_dsc,
  input  logic                              i_fixed_prio,
  output logic [P_NUM_SRC-1:0]              o_grant,
  output logic                              o_timeout
);
  localparam int GW = $clog2(P_NUM_SRC);
  localparam int CW = $clog2(P_TIMEOUT);
  localparam int PW = P_DATA_WIDTH + P_KEEP_WIDTH + TX_CTRL_W;
  tx_state_t               r_state, w_state_nx;
  logic [P_NUM_SRC-1:0]    r_grant, w_grant_nx, w_pick;
  logic [GW-1:0]           r_gidx, w_gidx_nx, r_ptr, w_ptr_nx, w_pick_idx, w_ptr_adv;
  logic [CW-1:0]           r_cnt, w_cnt_nx;
  logic                    r_timeout, w_timeout_nx;
  logic                    w_g_valid, w_g_last, w_to, w_in_valid, w_slice_rdy, w_out_valid, w_o_last, w_o_dsc;
  logic [P_DATA_WIDTH-1:0] w_g_data;
  logic [P_KEEP_WIDTH-1:0] w_g_keep;
  logic [PW-1:0]           w_in_data, w_out_data;
  assign w_g_valid = s_src_tvalid[r_gidx];
  assign w_g_last  = s_src_tlast[r_gidx];
  assign w_g_data  = s_src_tdata[r_gidx*P_DATA_WIDTH +: P_DATA_WIDTH];
  assign w_g_keep  = s_src_tkeep[r_gidx*P_KEEP_WIDTH +: P_KEEP_WIDTH];
  assign w_to      = r_cnt == CW'(P_TIMEOUT - 1);
  assign w_pick    = P_NUM_SRC'(onehot_rr(4'(s_src_tvalid), i_fixed_prio ? 2'd0 : 2'(r_ptr)));
  assign w_ptr_adv = (r_gidx == GW'(P_NUM_SRC - 1)) ? '0 : r_gidx + GW'(1);
  assign o_grant   = r_grant;
  assign o_timeout = r_timeout;
  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < P_NUM_SRC; i++) if (w_pick[i]) w_pick_idx = GW'(i);
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_gidx    <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_grant   <= w_grant_nx;
      r_gidx    <= w_gidx_nx;
      r_ptr     <= w_ptr_nx;
      r_cnt     <= w_cnt_nx;
      r_timeout <= w_timeout_nx;
    end
  end
  always_comb begin
    w_state_nx   = r_state;
    w_grant_nx   = r_grant;
    w_gidx_nx    = r_gidx;
    w_ptr_nx     = r_ptr;
    w_cnt_nx     = r_cnt;
    w_timeout_nx = r_timeout;
    w_in_valid   = 1'b0;
    w_in_data    = {w_g_data, w_g_keep, w_g_last, 1'b0};
    s_src_tready = '0;
    case (r_state)
      ST_IDLE: if (|s_src_tvalid) begin
        w_state_nx = ST_PKT;
        w_grant_nx = w_pick;
        w_gidx_nx  = w_pick_idx;
        w_cnt_nx   = '0;
      end
      ST_PKT: if (w_to) begin
        // abort beat waits for slice space, holding state and count
        w_in_valid = 1'b1;
        w_in_data  = {{P_DATA_WIDTH{1'b0}}, {P_KEEP_WIDTH{1'b1}}, 2'b11};
        if (w_slice_rdy) begin
          w_state_nx   = ST_DRAIN;
          w_timeout_nx = 1'b1;
        end
      end else begin
        w_in_valid           = w_g_valid;
        s_src_tready[r_gidx] = w_slice_rdy;
        if (w_g_valid && w_slice_rdy) begin
          w_cnt_nx = '0;
          if (w_g_last) begin
            w_state_nx = ST_IDLE;
            w_grant_nx = '0;
            w_ptr_nx   = i_fixed_prio ? r_ptr : w_ptr_adv;
          end
        end else if (!w_g_valid) w_cnt_nx = r_cnt + CW'(1);
      end
      ST_DRAIN: begin
        s_src_tready[r_gidx] = 1'b1;
        if (w_g_valid && w_g_last) begin
          w_state_nx = ST_IDLE;
          w_grant_nx = '0;
          w_ptr_nx   = i_fixed_prio ? r_ptr : w_ptr_adv;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end
  xilinx_pcie_axis_skid #(.P_W(PW)) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (w_in_valid),
    .i_data  (w_in_data),
    .o_ready (w_slice_rdy),
    .o_valid (w_out_valid),
    .o_data  (w_out_data),
    .i_ready (s_axis_tx_tready)
  );
  assign {s_axis_tx_tdata, s_axis_tx_tkeep, w_o_last, w_o_dsc} = w_out_data;
  assign s_axis_tx_tvalid = w_out_valid;
  assign s_axis_tx_tlast  = w_out_valid & w_o_last;
  assign tx_src_dsc       = w_out_valid & w_o_dsc;
endmodule

// File: doc/xilinx_pcie_tx_arbiter.md
Name: xilinx_pcie_tx_arbiter

Overview:
Packet-granular arbiter that shares the single 128-bit Xilinx PCIe core AXIS TX interface between several TLP sources, e.g. the PIO completer (source 0) and the DMA request engine (source 1).
- Grants one source per TLP, holds the grant until tlast, and registers the output through a skid slice so core tready does not feed source logic combinationally.
- A stall watchdog aborts a stuck packet using the core discontinue signal (tx_src_dsc).

Parameters:
P_DATA_WIDTH, 128, TX data width in bits
P_KEEP_WIDTH, P_DATA_WIDTH/8, tkeep width
P_NUM_SRC, 2, number of requesters (2..4)
P_TIMEOUT, 1024, idle-source stall cycles mid-packet before abort (>=2)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset; synchronous, active-low
s_src_tdata  in  P_NUM_SRC*P_DATA_WIDTH  source data, packed, source k at slice k
s_src_tkeep  in  P_NUM_SRC*P_KEEP_WIDTH  source keep
s_src_tlast  in  P_NUM_SRC  source last
s_src_tvalid  in  P_NUM_SRC  source valid
s_src_tready  out  P_NUM_SRC  source ready
s_axis_tx_tready  in  1  core ready
s_axis_tx_tdata  out  P_DATA_WIDTH  core data
s_axis_tx_tkeep  out  P_KEEP_WIDTH  core keep
s_axis_tx_tlast  out  1  core last
s_axis_tx_tvalid  out  1  core valid
tx_src_dsc  out  1  core discontinue, qualified by tvalid&tlast
i_fixed_prio  in  1  1 = source 0 strict priority, 0 = round-robin
o_grant  out  P_NUM_SRC  one-hot current grant, 0 in IDLE
o_timeout  out  1  sticky abort flag

Behaviour:
Reset values:
- All outputs 0: tvalid, tlast, tdata, tkeep, tx_src_dsc, s_src_tready, o_grant, o_timeout.
- Round-robin pointer = 0; FSM = IDLE; slice empty.

FSM states: IDLE, PKT, DRAIN.

IDLE:
- s_src_tready = 0.
- If any s_src_tvalid is high, register the grant and go to PKT.
- Fixed priority: lowest index wins.
- Round-robin: first valid index at or after the pointer, with wrap.

PKT:
- Granted source is muxed to the slice input; s_src_tready[g] = slice_ready; other readies 0.
- A beat with tlast accepted (tvalid & tready): go to IDLE; pointer = (g+1) mod P_NUM_SRC (round-robin mode only).
- There is exactly one arbitration bubble between packets; back-to-back TLPs are not required.

Watchdog (PKT only):
- Counter increments on each cycle the granted source has tvalid = 0.
- It clears on any accepted beat.
- Stalls caused by core backpressure (tvalid = 1, tready = 0) are not counted.
- At count == P_TIMEOUT-1, inject one beat into the slice: tdata = 0, tkeep all ones, tlast = 1, dsc = 1. Set o_timeout. Go to DRAIN.
- If the slice is not ready, injection waits, holding state and count.

DRAIN:
- s_src_tready[g] = 1; beats are discarded.
- On a discarded tlast beat, go to IDLE and advance the pointer.
- Beats received after the abort are always dropped, including the source's own tlast.

Slice:
- 2-entry skid register carrying {data, keep, last, dsc}.
- slice_ready = not full (registered).
- Output registered: a beat accepted at cycle n is presented at n+1 at the earliest.
- Output holds stable while tvalid & !tready (AXIS rule).

Latency: source tvalid in IDLE at cycle 0 -> grant at 1 -> first output beat valid at 2.

Changing i_fixed_prio mid-packet affects only the next arbitration.

Reset mid-packet: the slice is flushed, the partial TLP is not completed, and all state returns to reset values.

Decomposition:
- Package xilinx_pcie_tx_pkg: FSM state encodings (IDLE/PKT/DRAIN), slice payload width constant, function onehot_rr(valid, ptr).
- One sub-module, xilinx_pcie_axis_skid: the 2-entry registered slice, parameterized on payload width.

Test Plan:
- Src0 sends a 1-beat CplD (tkeep FFFF); src1 idle -> output beat at cycle 2, o_grant = 01 during PKT, then IDLE.
- Both sources valid with 3-beat packets, round-robin, pointer = 0 -> order src0, src1, src0, src1; exactly one idle cycle between packets.
- i_fixed_prio = 1, src0 and src1 continuously valid -> only src0 packets appear; src1 tready stays 0.
- Core tready toggles 1,0,0,1 within a 4-beat src1 packet -> no beat lost or duplicated; data held stable during stalls; watchdog not triggered.
- P_TIMEOUT = 8, src1 stops tvalid after beat 2 of 5 -> after 8 cycles one output beat with tlast = 1 and tx_src_dsc = 1; o_timeout = 1; src1's remaining 3 beats are drained with none output.
- Reset asserted mid-packet with the slice full -> next cycle all outputs 0; after release a new src0 packet goes out cleanly.
